prog_seq_ctrl: RTL and testbench
================================

Name: prog_seq_ctrl

Overview:
- Sequencing controller for the program counter: owns the PC's start/branch/target inputs and turns decoder requests (branch, call, return, halt) into PC commands.
- Implements the run/done handshake with the top level.
- Holds a small return-address stack and a run-cycle counter.
- Sits between the instruction decoder/ALU flags and the PC register.

Parameters:
- D, 8, program-counter width.
- STACK_DEPTH, 4, return-address stack entries (2..16).
- CW, 16, cycle-counter width.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- start  input  1  begin/restart program; sampled in IDLE or DONE.
- prog_ctr  input  D  current PC value, fed back from the PC register.
- halt_req  input  1  decoder: current instruction is halt.
- br_req  input  1  decoder: conditional/unconditional branch.
- br_cond  input  1  branch condition flag (tie 1 for unconditional).
- call_req  input  1  decoder: subroutine call.
- ret_req  input  1  decoder: subroutine return.
- br_target  input  D  branch/call destination.
- pc_start  output  1  drives PC start (PC clears to 0 next edge).
- pc_branch  output  1  drives PC branch.
- pc_target  output  D  drives PC target.
- busy  output  1  high in RUN.
- done  output  1  high in DONE.
- stack_err  output  1  sticky: stack overflow or underflow occurred.
- cycle_cnt  output  CW  RUN cycles executed in the current/last program.

Behaviour:
- States: IDLE, RUN, DONE. Next state is registered. pc_* outputs are combinational from state and inputs.
- Reset (reset==0 at posedge):
  - state=IDLE, stack empty (sp=0), cycle_cnt=0, stack_err=0.
  - Reset wins over every other input, including mid-RUN.
- IDLE:
  - pc_start=1, pc_branch=0, pc_target=0; busy=0, done=0.
  - start=1 -> RUN next edge. Also clears cycle_cnt, stack_err and sp.
- RUN:
  - pc_start=0. start is ignored.
  - Exactly one action per cycle, by priority: halt_req > ret_req > call_req > (br_req & br_cond) > increment.
  - halt_req: pc_branch=1, pc_target=prog_ctr (PC frozen at the halt address) -> DONE.
  - ret_req, sp>0: pc_branch=1, pc_target=stack[sp-1]; pop.
  - ret_req, sp==0 (underflow): stack_err<=1; PC frozen as for halt -> DONE.
  - call_req, sp<STACK_DEPTH: push (prog_ctr+1) mod 2^D; pc_branch=1, pc_target=br_target.
  - call_req, sp==STACK_DEPTH (overflow): stack_err<=1; PC frozen -> DONE; stack unchanged.
  - br_req & br_cond: pc_branch=1, pc_target=br_target.
  - br_req & !br_cond: falls to increment.
  - Increment: pc_branch=0; PC self-increments, wrapping 2^D-1 -> 0 with no flag.
  - Lower-priority requests asserted in the same cycle are dropped.
  - cycle_cnt increments every RUN cycle, including the halting cycle, and saturates at 2^CW-1.
- DONE:
  - done=1, busy=0; pc_branch=1, pc_target=prog_ctr (hold).
  - start=1 -> pc_start=1 that cycle (overrides hold in the PC), RUN next edge. Clears cycle_cnt, sp and stack_err.
  - Decoder requests are ignored.
- Latency: a request in RUN cycle N gives PC=target at edge N+1. start in IDLE/DONE gives PC=0 and busy=1 after one edge.
- Stack is registered LIFO; sp ranges 0..STACK_DEPTH. Contents past sp are don't-care.

Test Plan:
- Reset low 2 cycles, release, start pulse; no requests for 5 cycles, then halt_req -> PC 0,1,2,3,4,5 frozen at 5; done=1, busy=0, cycle_cnt=6.
- At PC=3: br_req=1, br_cond=0 -> PC 4. At PC=4: br_req=1, br_cond=1, br_target=0x40 -> PC 0x40.
- Call to 0x20 at PC=2, call to 0x30 at PC=0x21, ret at 0x31, ret at 0x23 -> PC sequence …0x20, 0x21, 0x30, 0x31, 0x22, 0x23, 0x03; stack_err=0.
- STACK_DEPTH=4: five nested calls -> fifth call leaves PC frozen at its own address, stack_err=1, done=1. Separate run: ret with empty stack -> stack_err=1, DONE.
- halt_req+call_req+br_req same cycle at PC=7 -> halt wins, PC stays 7, no push. ret_req+call_req -> ret wins, sp decrements.
- reset=0 in RUN at PC=0x12 with sp=2 -> IDLE next edge, sp=0, pc_start=1. Separately, start in DONE -> PC=0, cycle_cnt=0, stack_err=0, busy=1. CW=4: 20-cycle run -> cycle_cnt=15.

Source files
------------

// File: rtl/prog_seq_ctrl.sv
// Program sequencing controller: drives the PC start/branch/target controls,
// runs the IDLE/RUN/DONE handshake, and keeps a return-address stack and a run-cycle counter.
module prog_seq_ctrl #(
  parameter int D           = 8,
  parameter int STACK_DEPTH = 4,
  parameter int CW          = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [D-1:0]  prog_ctr,
  input  logic          halt_req,
  input  logic          br_req,
  input  logic          br_cond,
  input  logic          call_req,
  input  logic          ret_req,
  input  logic [D-1:0]  br_target,
  output logic          pc_start,
  output logic          pc_branch,
  output logic [D-1:0]  pc_target,
  output logic          busy,
  output logic          done,
  output logic          stack_err,
  output logic [CW-1:0] cycle_cnt
);

  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int AW  = $clog2(STACK_DEPTH);
  localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [SPW-1:0] sp;
  logic [D-1:0]   stack [STACK_DEPTH];
  logic [AW-1:0]  push_idx, top_idx;
  logic           push, pop, err_set, clr;

  assign push_idx = AW'(sp);
  assign top_idx  = AW'(sp - 1'b1);
  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d   = state_q;
    pc_start  = 1'b0;
    pc_branch = 1'b0;
    pc_target = '0;
    push      = 1'b0;
    pop       = 1'b0;
    err_set   = 1'b0;
    clr       = 1'b0;
    unique case (state_q)
      IDLE: begin
        pc_start = 1'b1;
        if (start) begin
          state_d = RUN;
          clr     = 1'b1;
        end
      end
      RUN: begin
        // One action per cycle; lower-priority requests in the same cycle are dropped.
        if (halt_req) begin
          pc_branch = 1'b1;
          pc_target = prog_ctr;
          state_d   = DONE;
        end else if (ret_req) begin
          pc_branch = 1'b1;
          if (sp != '0) begin
            pc_target = stack[top_idx];
            pop       = 1'b1;
          end else begin
            pc_target = prog_ctr;
            err_set   = 1'b1;
            state_d   = DONE;
          end
        end else if (call_req) begin
          pc_branch = 1'b1;
          if (sp != SP_FULL) begin
            pc_target = br_target;
            push      = 1'b1;
          end else begin
            pc_target = prog_ctr;
            err_set   = 1'b1;
            state_d   = DONE;
          end
        end else if (br_req && br_cond) begin
          pc_branch = 1'b1;
          pc_target = br_target;
        end
      end
      DONE: begin
        pc_branch = 1'b1;
        pc_target = prog_ctr;
        if (start) begin
          pc_start = 1'b1;
          state_d  = RUN;
          clr      = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (!reset) begin
      state_q   <= IDLE;
      sp        <= '0;
      stack_err <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (clr) begin
        sp        <= '0;
        stack_err <= 1'b0;
        cycle_cnt <= '0;
      end else begin
        if (push)     sp <= sp + 1'b1;
        else if (pop) sp <= sp - 1'b1;
        if (err_set)  stack_err <= 1'b1;
        if (state_q == RUN && cycle_cnt != '1) cycle_cnt <= cycle_cnt + 1'b1;
      end
    end
  end

  // NOTE: stack storage is deliberately not reset; entries at or above sp are never read.
  always_ff @(posedge clk) begin
    if (push) stack[push_idx] <= prog_ctr + 1'b1;
  end

endmodule

// File: tb/tb_prog_seq_ctrl.sv
// Bench for prog_seq_ctrl: closes the loop with a behavioural PC register and
// scoreboards the PC sequence; a CW=4 twin checks cycle-counter saturation.
module tb_prog_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, halt_req, br_req, br_cond, call_req, ret_req;
  logic [7:0] br_target;
  logic [7:0] pc;

  logic        pc_start, pc_branch, busy, done, stack_err;
  logic [7:0]  pc_target;
  logic [15:0] cycle_cnt;

  logic        s_pc_start, s_pc_branch, s_busy, s_done, s_stack_err;
  logic [7:0]  s_pc_target;
  logic [3:0]  s_cycle_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       halt, ret, call, br, cond;
    logic [7:0] tgt;
    logic [7:0] exp_pc;
  } stim_t;

  stim_t      stim[$];
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];

  always #5 clk = ~clk;

  prog_seq_ctrl #(.D(8), .STACK_DEPTH(4), .CW(16)) dut (
    .clk(clk), .reset(reset), .start(start), .prog_ctr(pc),
    .halt_req(halt_req), .br_req(br_req), .br_cond(br_cond),
    .call_req(call_req), .ret_req(ret_req), .br_target(br_target),
    .pc_start(pc_start), .pc_branch(pc_branch), .pc_target(pc_target),
    .busy(busy), .done(done), .stack_err(stack_err), .cycle_cnt(cycle_cnt)
  );

  prog_seq_ctrl #(.D(8), .STACK_DEPTH(4), .CW(4)) dut_sat (
    .clk(clk), .reset(reset), .start(start), .prog_ctr(pc),
    .halt_req(halt_req), .br_req(br_req), .br_cond(br_cond),
    .call_req(call_req), .ret_req(ret_req), .br_target(br_target),
    .pc_start(s_pc_start), .pc_branch(s_pc_branch), .pc_target(s_pc_target),
    .busy(s_busy), .done(s_done), .stack_err(s_stack_err), .cycle_cnt(s_cycle_cnt)
  );

  // PC register the controller drives: start clears, branch loads, otherwise increment.
  always @(posedge clk) begin
    if (pc_start)       pc <= 8'h00;
    else if (pc_branch) pc <= pc_target;
    else                pc <= pc + 8'h01;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic stim_t mk(input logic h, r, c, b, cd, input logic [7:0] t, e);
    mk = '{halt: h, ret: r, call: c, br: b, cond: cd, tgt: t, exp_pc: e};
  endfunction

  task automatic clear_reqs();
    halt_req = 0; ret_req = 0; call_req = 0; br_req = 0; br_cond = 0; br_target = 8'h00;
  endtask

  task automatic do_start();
    start = 1;
    tick();
    start = 0;
  endtask

  // Drives the queued stimulus one cycle each, pushing expected PC at drive time
  // and the observed PC after the edge.
  task automatic run_prog();
    while (stim.size() > 0) begin
      stim_t s;
      s = stim.pop_front();
      halt_req = s.halt; ret_req = s.ret; call_req = s.call;
      br_req = s.br; br_cond = s.cond; br_target = s.tgt;
      exp_q.push_back(s.exp_pc);
      tick();
      obs_q.push_back(pc);
      clear_reqs();
    end
  endtask

  task automatic test_reset();
    reset = 0; start = 0; clear_reqs();
    tick(); tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_status busy=%b done=%b want 0 0", busy, done); end
    checks++; if (pc_start !== 1'b1 || pc_branch !== 1'b0 || pc_target !== 8'h00) begin errors++; $display("FAIL reset_pc_ctl start=%b branch=%b target=%h want 1 0 00", pc_start, pc_branch, pc_target); end
    checks++; if (stack_err !== 1'b0 || cycle_cnt !== 16'd0) begin errors++; $display("FAIL reset_regs err=%b cnt=%0d want 0 0", stack_err, cycle_cnt); end
    reset = 1;
    tick();
    checks++; if (pc !== 8'h00 || busy !== 1'b0) begin errors++; $display("FAIL idle_hold pc=%h busy=%b want 00 0", pc, busy); end
  endtask

  task automatic test_halt();
    int n;
    do_start();
    checks++; if (pc !== 8'h00 || busy !== 1'b1 || cycle_cnt !== 16'd0) begin errors++; $display("FAIL start_idle pc=%h busy=%b cnt=%0d want 00 1 0", pc, busy, cycle_cnt); end
    for (int i = 1; i <= 5; i++) stim.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'(i)));
    stim.push_back(mk(1, 0, 0, 0, 0, 8'h00, 8'h05));
    stim.push_back(mk(0, 0, 1, 1, 1, 8'h77, 8'h05));  // DONE ignores requests
    run_prog();
    n = 0;
    while (exp_q.size() > 0) begin
      logic [7:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n++;
      checks++; if (o !== e) begin errors++; $display("FAIL halt_seq[%0d] pc=%h want %h", n, o, e); end
    end
    checks++; if (done !== 1'b1 || busy !== 1'b0 || cycle_cnt !== 16'd6) begin errors++; $display("FAIL halt_done done=%b busy=%b cnt=%0d want 1 0 6", done, busy, cycle_cnt); end
  endtask

  task automatic test_branch();
    int n;
    do_start();
    stim.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h01));
    stim.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h02));
    stim.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h03));
    stim.push_back(mk(0, 0, 0, 1, 0, 8'h55, 8'h04));  // untaken branch
    stim.push_back(mk(0, 0, 0, 1, 1, 8'h40, 8'h40));
    stim.push_back(mk(0, 0, 0, 1, 1, 8'hFE, 8'hFE));
    stim.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'hFF));
    stim.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h00));  // PC wrap
    stim.push_back(mk(1, 0, 0, 0, 0, 8'h00, 8'h00));
    run_prog();
    n = 0;
    while (exp_q.size() > 0) begin
      logic [7:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n++;
      checks++; if (o !== e) begin errors++; $display("FAIL branch_seq[%0d] pc=%h want %h", n, o, e); end
    end
    checks++; if (done !== 1'b1 || stack_err !== 1'b0) begin errors++; $display("FAIL branch_done done=%b err=%b want 1 0", done, stack_err); end
  endtask

  task automatic test_call_ret();
    int n;
    do_start();
    stim.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h01));
    stim.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h02));
    stim.push_back(mk(0, 0, 1, 0, 0, 8'h20, 8'h20));
    stim.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h21));
    stim.push_back(mk(0, 0, 1, 0, 0, 8'h30, 8'h30));
    stim.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h31));
    stim.push_back(mk(0, 1, 0, 0, 0, 8'h00, 8'h22));
    stim.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h23));
    stim.push_back(mk(0, 1, 0, 0, 0, 8'h00, 8'h03));
    stim.push_back(mk(1, 0, 0, 0, 0, 8'h00, 8'h03));
    run_prog();
    n = 0;
    while (exp_q.size() > 0) begin
      logic [7:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n++;
      checks++; if (o !== e) begin errors++; $display("FAIL call_seq[%0d] pc=%h want %h", n, o, e); end
    end
    checks++; if (stack_err !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL call_done err=%b done=%b want 0 1", stack_err, done); end
  endtask

  task automatic test_overflow();
    int n;
    do_start();
    stim.push_back(mk(0, 0, 1, 0, 0, 8'h10, 8'h10));
    stim.push_back(mk(0, 0, 1, 0, 0, 8'h20, 8'h20));
    stim.push_back(mk(0, 0, 1, 0, 0, 8'h30, 8'h30));
    stim.push_back(mk(0, 0, 1, 0, 0, 8'h40, 8'h40));
    stim.push_back(mk(0, 0, 1, 0, 0, 8'h50, 8'h40));  // fifth call overflows
    stim.push_back(mk(0, 1, 0, 0, 0, 8'h00, 8'h40));
    run_prog();
    n = 0;
    while (exp_q.size() > 0) begin
      logic [7:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n++;
      checks++; if (o !== e) begin errors++; $display("FAIL ovf_seq[%0d] pc=%h want %h", n, o, e); end
    end
    checks++; if (stack_err !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL ovf_status err=%b done=%b busy=%b want 1 1 0", stack_err, done, busy); end
  endtask

  task automatic test_restart_underflow();
    start = 1;
    #1;
    checks++; if (pc_start !== 1'b1) begin errors++; $display("FAIL done_start pc_start=%b want 1", pc_start); end
    tick();
    start = 0;
    checks++; if (pc !== 8'h00 || cycle_cnt !== 16'd0 || stack_err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL restart pc=%h cnt=%0d err=%b busy=%b want 00 0 0 1", pc, cycle_cnt, stack_err, busy); end
    stim.push_back(mk(0, 1, 0, 0, 0, 8'h00, 8'h00));
    run_prog();
    while (exp_q.size() > 0) begin
      logic [7:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL udf_pc pc=%h want %h", o, e); end
    end
    checks++; if (stack_err !== 1'b1 || done !== 1'b1) begin errors++; $display("FAIL udf_status err=%b done=%b want 1 1", stack_err, done); end
  endtask

  task automatic test_priority();
    int n;
    do_start();
    for (int i = 1; i <= 7; i++) stim.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'(i)));
    stim.push_back(mk(1, 0, 1, 1, 1, 8'h60, 8'h07));
    run_prog();
    n = 0;
    while (exp_q.size() > 0) begin
      logic [7:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n++;
      checks++; if (o !== e) begin errors++; $display("FAIL prio_halt[%0d] pc=%h want %h", n, o, e); end
    end
    checks++; if (done !== 1'b1 || stack_err !== 1'b0) begin errors++; $display("FAIL prio_halt_status done=%b err=%b want 1 0", done, stack_err); end
    do_start();
    stim.push_back(mk(0, 0, 1, 0, 0, 8'h10, 8'h10));
    stim.push_back(mk(0, 1, 1, 0, 0, 8'h70, 8'h01));  // ret beats call
    stim.push_back(mk(0, 1, 0, 0, 0, 8'h00, 8'h01));  // stack now empty
    run_prog();
    n = 0;
    while (exp_q.size() > 0) begin
      logic [7:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n++;
      checks++; if (o !== e) begin errors++; $display("FAIL prio_ret[%0d] pc=%h want %h", n, o, e); end
    end
    checks++; if (stack_err !== 1'b1 || done !== 1'b1) begin errors++; $display("FAIL prio_ret_status err=%b done=%b want 1 1", stack_err, done); end
  endtask

  task automatic test_reset_mid_run();
    int n;
    do_start();
    stim.push_back(mk(0, 0, 1, 0, 0, 8'h10, 8'h10));
    stim.push_back(mk(0, 0, 1, 0, 0, 8'h12, 8'h12));
    run_prog();
    n = 0;
    while (exp_q.size() > 0) begin
      logic [7:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n++;
      checks++; if (o !== e) begin errors++; $display("FAIL rst_run_seq[%0d] pc=%h want %h", n, o, e); end
    end
    reset = 0;
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0 || pc_start !== 1'b1 || cycle_cnt !== 16'd0) begin errors++; $display("FAIL rst_mid busy=%b done=%b pc_start=%b cnt=%0d want 0 0 1 0", busy, done, pc_start, cycle_cnt); end
    reset = 1;
    tick();
    do_start();
    stim.push_back(mk(0, 1, 0, 0, 0, 8'h00, 8'h00));
    run_prog();
    while (exp_q.size() > 0) begin
      logic [7:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL rst_sp_pc pc=%h want %h", o, e); end
    end
    checks++; if (stack_err !== 1'b1 || done !== 1'b1) begin errors++; $display("FAIL rst_sp_empty err=%b done=%b want 1 1", stack_err, done); end
  endtask

  task automatic test_saturate();
    int n;
    do_start();
    for (int i = 1; i <= 20; i++) stim.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'(i)));
    run_prog();
    n = 0;
    while (exp_q.size() > 0) begin
      logic [7:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n++;
      checks++; if (o !== e) begin errors++; $display("FAIL sat_seq[%0d] pc=%h want %h", n, o, e); end
    end
    checks++; if (cycle_cnt !== 16'd20) begin errors++; $display("FAIL cnt_wide cnt=%0d want 20", cycle_cnt); end
    checks++; if (s_cycle_cnt !== 4'd15 || s_busy !== 1'b1) begin errors++; $display("FAIL cnt_sat cnt=%0d busy=%b want 15 1", s_cycle_cnt, s_busy); end
  endtask

  initial begin
    test_reset();
    test_halt();
    test_branch();
    test_call_ret();
    test_overflow();
    test_restart_underflow();
    test_priority();
    test_reset_mid_run();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
